// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-port synchronous data RAM between the CPU data port and a
//   secondary requester (DMA / debug loader). One access is granted per cycle;
//   a losing CPU access is stalled, a losing DMA request simply waits for its ack.
//   Read data (1-cycle RAM latency) is steered back to whoever issued the read.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : contended cycles alternate winners via rr_ptr, WAIT_MAX unused
//     undefined : CPU priority, DMA forced through after WAIT_MAX lost cycles
//
//   Handshake summary: the CPU presents cpu_rd/cpu_wr and holds them (with
//   address/data) for every cycle cpu_stall is high; the access completes in the
//   first cycle cpu_stall is low. The DMA holds dma_req (with dma_we/addr/wdata)
//   until the cycle dma_ack is high; that cycle is the access. A DMA read returns
//   dma_rdata with a dma_rvalid pulse on the following cycle. dma_req may be
//   dropped before ack, which cancels the request without any RAM access.
module data_mem_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 16,
  parameter int WAIT_MAX = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int WCW = $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(WAIT_MAX);

  // Requester encodings for rr_ptr.
  localparam logic [0:0] OWN_CPU = 1'b0;
  localparam logic [0:0] OWN_DMA = 1'b1;

  logic           cpu_req;
  logic           cpu_grant;
  logic           dma_grant;
  logic           dma_first;
  logic [WCW-1:0] wait_cnt;
  logic [0:0]     rr_ptr;
  logic           rd_cpu_q;
  logic           rd_dma_q;
  logic           rd_cpu_live;
  logic           rd_dma_live;
  logic [DW-1:0]  cpu_rdata_q;
  logic [DW-1:0]  dma_rdata_q;

  assign cpu_req = cpu_rd | cpu_wr;

`ifdef ARB_ROUND_ROBIN_EN
  // Contention winner is whoever rr_ptr points at.
  always_comb begin
    dma_first = (rr_ptr == OWN_DMA);
  end

  // Pointer moves to the other requester after every contended grant.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rr_ptr <= OWN_CPU;
    end else if (cpu_req && dma_req) begin
      rr_ptr <= dma_grant ? OWN_CPU : OWN_DMA;
    end
  end
`else
  // Fixed CPU priority; rr_ptr is constantly CPU in this build.
  assign rr_ptr = OWN_CPU;

  // DMA wins a contended cycle only once it has lost WAIT_MAX times in a row.
  always_comb begin
    dma_first = (wait_cnt == WAIT_LIM) || (rr_ptr == OWN_DMA);
  end
`endif

  // Grant decision: a lone requester always wins.
  always_comb begin
    dma_grant = dma_req & (~cpu_req | dma_first);
    cpu_grant = cpu_req & ~dma_grant;
  end

  // RAM port mux; strobes are suppressed while Reset is high.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (dma_grant) begin
      mem_rd    = ~dma_we;
      mem_wr    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (cpu_grant) begin
      // Simultaneous rd+wr behaves as a read, like the RAM itself.
      mem_rd = cpu_rd;
      mem_wr = cpu_wr & ~cpu_rd;
    end
    if (Reset) begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
    end
  end

  // Handshake outputs toward the two requesters.
  always_comb begin
    cpu_stall = cpu_req & ~cpu_grant & ~Reset;
    dma_ack   = dma_req & dma_grant & ~Reset;
  end

  // Starvation counter: counts consecutive lost DMA cycles, saturating.
  always_ff @(posedge Clock) begin
    if (Reset || !dma_req || dma_ack) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIM) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Remember who owns the read issued this cycle so data returns to them.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_cpu_q <= 1'b0;
      rd_dma_q <= 1'b0;
    end else begin
      rd_cpu_q <= cpu_grant & cpu_rd;
      rd_dma_q <= dma_grant & ~dma_we;
    end
  end

  // A return cycle that overlaps Reset is discarded.
  always_comb begin
    rd_cpu_live = rd_cpu_q & ~Reset;
    rd_dma_live = rd_dma_q & ~Reset;
  end

  // Hold registers keep the last delivered read value for each side.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (rd_cpu_live) cpu_rdata_q <= mem_rdata;
      if (rd_dma_live) dma_rdata_q <= mem_rdata;
    end
  end

  // Read data steering: live RAM data on the return cycle, held value otherwise.
  always_comb begin
    cpu_rdata  = rd_cpu_live ? mem_rdata : cpu_rdata_q;
    dma_rdata  = rd_dma_live ? mem_rdata : dma_rdata_q;
    dma_rvalid = rd_dma_live;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//   Table-driven bench for data_mem_arbiter with a behavioural single-port RAM.
//   Each table row is one clock cycle: inputs driven after posedge, outputs
//   compared at the following negedge. Multi-cycle corners (reset during a read
//   return, contended read routing) are hand-written sequences.
module tb_data_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          rst, crd, cwr;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    logic          dreq, dwe;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwd;
    logic          stall, ack, rv, mrd, mwr;
    logic [AW-1:0] maddr;
    logic [DW-1:0] crdata, drdata;
  } vec_t;

  vec_t vecs[$];

  data_mem_arbiter #(.AW(AW), .DW(DW), .WAIT_MAX(4)) dut (
    .Clock(clk), .Reset(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous RAM: read has priority, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= ram[mem_addr];
    else if (mem_wr) ram[mem_addr] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Driver: one cycle of inputs applied just after the rising edge.
  task automatic drive(input logic r, crd, cwr, input logic [AW-1:0] caddr,
                       input logic [DW-1:0] cwd, input logic dreq, dwe,
                       input logic [AW-1:0] daddr, input logic [DW-1:0] dwd);
    @(posedge clk);
    #1;
    rst = r; cpu_rd = crd; cpu_wr = cwr; cpu_addr = caddr; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
    @(negedge clk);
  endtask

  function automatic void add(input logic r, crd, cwr, input logic [AW-1:0] caddr,
                              input logic [DW-1:0] cwd, input logic dreq, dwe,
                              input logic [AW-1:0] daddr, input logic [DW-1:0] dwd,
                              input logic stall, ack, rv, mrd, mwr,
                              input logic [AW-1:0] maddr,
                              input logic [DW-1:0] crdata, drdata);
    vec_t v;
    v.rst = r; v.crd = crd; v.cwr = cwr; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.stall = stall; v.ack = ack; v.rv = rv; v.mrd = mrd; v.mwr = mwr;
    v.maddr = maddr; v.crdata = crdata; v.drdata = drdata;
    vecs.push_back(v);
  endfunction

  initial begin
    for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
    ram[2] = 16'h0A22;
    ram[3] = 16'h0B33;
    mem_rdata = '0;
    rst = 1'b1; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;

    // rst crd cwr caddr cwd | dreq dwe daddr dwd | stall ack rv mrd mwr maddr | crdata drdata
    // Reset: strobes/stall/ack forced low even with requests present.
    add(1, 1, 0, 0, 16'h0, 1, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    add(1, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    // CPU only: wr 0<-1, wr 1<-2, rd 0, rd 1.
    add(0, 0, 1, 0, 16'h1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0);
    add(0, 0, 1, 1, 16'h2, 0, 0, 0, 16'h0, 0, 0, 0, 0, 1, 1, 16'h0, 16'h0);
    add(0, 1, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0);
    add(0, 1, 0, 1, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0, 1, 0, 1, 16'h1, 16'h0);
    add(0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h2, 16'h0);
    add(0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h2, 16'h0);
    // DMA only: write 5<-BEEF, read 5.
    add(0, 0, 0, 0, 16'h0, 1, 1, 5, 16'hBEEF, 0, 1, 0, 0, 1, 5, 16'h2, 16'h0);
    add(0, 0, 0, 0, 16'h0, 1, 0, 5, 16'h0,    0, 1, 0, 1, 0, 5, 16'h2, 16'h0);
    add(0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0,    0, 0, 1, 0, 0, 0, 16'h2, 16'hBEEF);
    add(0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 0, 16'h2, 16'h0);
`ifndef ARB_ROUND_ROBIN_EN
    // CPU read held, DMA write 7<-0042: DMA loses 4 cycles, wins the 5th.
    add(0, 1, 0, 0, 16'h0, 1, 1, 7, 16'h0042, 0, 0, 0, 1, 0, 0, 16'h2, 16'h0);
    add(0, 1, 0, 0, 16'h0, 1, 1, 7, 16'h0042, 0, 0, 0, 1, 0, 0, 16'h1, 16'h0);
    add(0, 1, 0, 0, 16'h0, 1, 1, 7, 16'h0042, 0, 0, 0, 1, 0, 0, 16'h1, 16'h0);
    add(0, 1, 0, 0, 16'h0, 1, 1, 7, 16'h0042, 0, 0, 0, 1, 0, 0, 16'h1, 16'h0);
    add(0, 1, 0, 0, 16'h0, 1, 1, 7, 16'h0042, 1, 1, 0, 0, 1, 7, 16'h1, 16'h0);
    add(0, 1, 0, 0, 16'h0, 0, 0, 0, 16'h0,    0, 0, 0, 1, 0, 0, 16'h1, 16'h0);
    add(0, 1, 0, 7, 16'h0, 0, 0, 0, 16'h0,    0, 0, 0, 1, 0, 7, 16'h1, 16'h0);
    add(0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0,    0, 0, 0, 0, 0, 0, 16'h0042, 16'h0);
    // rd+wr at addr 1 acts as a read; DMA read request withdrawn after 2 cycles.
    add(0, 1, 1, 1, 16'hDEAD, 1, 0, 3, 16'h0, 0, 0, 0, 1, 0, 1, 16'h0042, 16'h0);
    add(0, 1, 1, 1, 16'hDEAD, 1, 0, 3, 16'h0, 0, 0, 0, 1, 0, 1, 16'h2, 16'h0);
    add(0, 1, 1, 1, 16'hDEAD, 0, 0, 0, 16'h0, 0, 0, 0, 1, 0, 1, 16'h2, 16'h0);
    add(0, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 16'h2, 16'h0);
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].crd, vecs[i].cwr, vecs[i].caddr, vecs[i].cwd,
            vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwd);
      check($sformatf("v%0d cpu_stall", i), 32'(cpu_stall), 32'(vecs[i].stall));
      check($sformatf("v%0d dma_ack", i), 32'(dma_ack), 32'(vecs[i].ack));
      check($sformatf("v%0d dma_rvalid", i), 32'(dma_rvalid), 32'(vecs[i].rv));
      check($sformatf("v%0d mem_rd", i), 32'(mem_rd), 32'(vecs[i].mrd));
      check($sformatf("v%0d mem_wr", i), 32'(mem_wr), 32'(vecs[i].mwr));
      if (vecs[i].mrd || vecs[i].mwr)
        check($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
      check($sformatf("v%0d cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].crdata));
      if (vecs[i].rv)
        check($sformatf("v%0d dma_rdata", i), 32'(dma_rdata), 32'(vecs[i].drdata));
    end
    check("wait_cnt after table", 32'(dut.wait_cnt), 32'd0);
`ifndef ARB_ROUND_ROBIN_EN
    check("ram[7] dma write", 32'(ram[7]), 32'h0042);
    check("ram[1] untouched by rd+wr", 32'(ram[1]), 32'h2);
`endif

    // Reset asserted on the cycle after a DMA read ack: the return is dropped.
    drive(0, 0, 0, 0, 16'h0, 1, 0, 5, 16'h0);
    check("rst_seq ack", 32'(dma_ack), 32'd1);
    check("rst_seq mem_rd", 32'(mem_rd), 32'd1);
    drive(1, 1, 0, 0, 16'h0, 1, 1, 9, 16'h1234);
    check("rst_seq rvalid in reset", 32'(dma_rvalid), 32'd0);
    check("rst_seq mem_rd in reset", 32'(mem_rd), 32'd0);
    check("rst_seq mem_wr in reset", 32'(mem_wr), 32'd0);
    check("rst_seq ack in reset", 32'(dma_ack), 32'd0);
    check("rst_seq stall in reset", 32'(cpu_stall), 32'd0);
    drive(0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    check("rst_seq rvalid after", 32'(dma_rvalid), 32'd0);
    check("rst_seq wait_cnt", 32'(dut.wait_cnt), 32'd0);
    check("rst_seq cpu_rdata cleared", 32'(cpu_rdata), 32'd0);
    check("rst_seq ram[9] unwritten", 32'(ram[9]), 32'd0);

    // Contended reads: CPU addr 2, DMA addr 3, both held for three cycles.
    drive(0, 1, 0, 2, 16'h0, 1, 0, 3, 16'h0);
    check("rr c0 stall", 32'(cpu_stall), 32'd0);
    check("rr c0 ack", 32'(dma_ack), 32'd0);
    check("rr c0 mem_addr", 32'(mem_addr), 32'd2);
    exp_q.push_back(16'h0A22);
    drive(0, 1, 0, 2, 16'h0, 1, 0, 3, 16'h0);
    check("rr c1 cpu_rdata", 32'(cpu_rdata), 32'(exp_q.pop_front()));
`ifdef ARB_ROUND_ROBIN_EN
    check("rr c1 stall", 32'(cpu_stall), 32'd1);
    check("rr c1 ack", 32'(dma_ack), 32'd1);
    check("rr c1 mem_addr", 32'(mem_addr), 32'd3);
    exp_q.push_back(16'h0B33);
    drive(0, 1, 0, 2, 16'h0, 1, 0, 3, 16'h0);
    check("rr c2 stall", 32'(cpu_stall), 32'd0);
    check("rr c2 ack", 32'(dma_ack), 32'd0);
    check("rr c2 rvalid", 32'(dma_rvalid), 32'd1);
    check("rr c2 dma_rdata", 32'(dma_rdata), 32'(exp_q.pop_front()));
    check("rr c2 cpu_rdata held", 32'(cpu_rdata), 32'h0A22);
`else
    check("pri c1 stall", 32'(cpu_stall), 32'd0);
    check("pri c1 ack", 32'(dma_ack), 32'd0);
    check("pri c1 mem_addr", 32'(mem_addr), 32'd2);
    exp_q.push_back(16'h0A22);
    drive(0, 1, 0, 2, 16'h0, 1, 0, 3, 16'h0);
    check("pri c2 stall", 32'(cpu_stall), 32'd0);
    check("pri c2 rvalid", 32'(dma_rvalid), 32'd0);
    check("pri c2 cpu_rdata", 32'(cpu_rdata), 32'(exp_q.pop_front()));
    check("pri c2 wait_cnt", 32'(dut.wait_cnt), 32'd2);
`endif
    drive(0, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    check("rr c3 cpu_rdata", 32'(cpu_rdata), 32'h0A22);
    check("rr c3 rvalid", 32'(dma_rvalid), 32'd0);
    check("rr exp_q drained", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
